// File: rtl/sensor_frontend_if.sv
// Raw temperature sample handshake between a sensor source and sensor_frontend.
// The source drives valid/data and must hold them until it sees ready.
interface sensor_frontend_if;
   logic       sample_valid;
   logic [7:0] sample_data;
   logic       sample_ready;

   modport master (
      output sample_valid,
      output sample_data,
      input  sample_ready
   );

   modport slave (
      input  sample_valid,
      input  sample_data,
      output sample_ready
   );
endinterface

// File: rtl/sensor_frontend.sv
// Sensor conditioning ahead of the air-conditioning controller: a clamped moving
// average of temperature samples plus a synchronised, debounced and held PIR flag.
module sensor_frontend #(
   parameter int unsigned AVG_LOG2    = 2,
   parameter int unsigned DEBOUNCE    = 4,
   parameter int unsigned HOLD_CYCLES = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   sensor_frontend_if.slave    smp,
   input  logic                pir_raw,
   output logic [6:0]          temperature,
   output logic                temp_valid,
   output logic                humanDetector
);

   localparam int unsigned Depth = 1 << AVG_LOG2;
   localparam int unsigned SumW  = 7 + AVG_LOG2;
   localparam int unsigned DbW   = $clog2(DEBOUNCE + 1);
   localparam int unsigned HoldW = $clog2(HOLD_CYCLES + 1);

   typedef enum logic [1:0] {StIdle, StAccum, StOutput} state_e;

   state_e              state_q, state_d;
   logic                ready_q, ready_d;
   logic                first_q, first_d;
   logic [6:0]          new_q, new_d;
   logic [6:0]          ring_q [Depth];
   logic [6:0]          ring_d [Depth];
   logic [AVG_LOG2-1:0] wr_ptr_q, wr_ptr_d;
   logic [SumW-1:0]     sum_q, sum_d;
   logic [6:0]          temperature_q, temperature_d;
   logic                temp_valid_q, temp_valid_d;

   logic                sync1_q, sync2_q;
   logic                pir_db_q, pir_db_d;
   logic [DbW-1:0]      db_cnt_q, db_cnt_d;
   logic [HoldW-1:0]    hold_q, hold_d;
   logic                human_q, human_d;

   logic                accept;
   logic [6:0]          clamped;

   assign accept  = smp.sample_valid & ready_q;
   assign clamped = smp.sample_data[7] ? 7'd0 : smp.sample_data[6:0];

   always_comb begin
      state_d       = state_q;
      first_d       = first_q;
      new_d         = new_q;
      ring_d        = ring_q;
      wr_ptr_d      = wr_ptr_q;
      sum_d         = sum_q;
      temperature_d = temperature_q;
      temp_valid_d  = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (accept) begin
               new_d   = clamped;
               state_d = StAccum;
            end
         end
         StAccum: begin
            if (first_q) begin
               // Preload the whole window so the first output equals the first sample.
               for (int i = 0; i < Depth; i++) ring_d[i] = new_q;
               sum_d   = SumW'(new_q) << AVG_LOG2;
               first_d = 1'b0;
            end else begin
               sum_d            = sum_q - SumW'(ring_q[wr_ptr_q]) + SumW'(new_q);
               ring_d[wr_ptr_q] = new_q;
               wr_ptr_d         = wr_ptr_q + 1'b1;
            end
            state_d = StOutput;
         end
         StOutput: begin
            temperature_d = 7'(sum_q >> AVG_LOG2);
            temp_valid_d  = 1'b1;
            state_d       = StIdle;
         end
         default: state_d = StIdle;
      endcase
      // Registered ready keeps it low while in reset and for the first edge after.
      ready_d = (state_d == StIdle);
   end

   always_comb begin
      pir_db_d = pir_db_q;
      db_cnt_d = '0;
      if (sync2_q != pir_db_q) begin
         if (db_cnt_q == DbW'(DEBOUNCE - 1)) begin
            pir_db_d = sync2_q;
         end else begin
            db_cnt_d = db_cnt_q + 1'b1;
         end
      end

      if (pir_db_q) begin
         hold_d = HoldW'(HOLD_CYCLES);
      end else if (hold_q != '0) begin
         hold_d = hold_q - 1'b1;
      end else begin
         hold_d = '0;
      end

      human_d = pir_db_q | (hold_q != '0);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= StIdle;
         ready_q       <= 1'b0;
         first_q       <= 1'b1;
         new_q         <= '0;
         for (int i = 0; i < Depth; i++) ring_q[i] <= '0;
         wr_ptr_q      <= '0;
         sum_q         <= '0;
         temperature_q <= '0;
         temp_valid_q  <= 1'b0;
         sync1_q       <= 1'b0;
         sync2_q       <= 1'b0;
         pir_db_q      <= 1'b0;
         db_cnt_q      <= '0;
         hold_q        <= '0;
         human_q       <= 1'b0;
      end else begin
         state_q       <= state_d;
         ready_q       <= ready_d;
         first_q       <= first_d;
         new_q         <= new_d;
         ring_q        <= ring_d;
         wr_ptr_q      <= wr_ptr_d;
         sum_q         <= sum_d;
         temperature_q <= temperature_d;
         temp_valid_q  <= temp_valid_d;
         sync1_q       <= pir_raw;
         sync2_q       <= sync1_q;
         pir_db_q      <= pir_db_d;
         db_cnt_q      <= db_cnt_d;
         hold_q        <= hold_d;
         human_q       <= human_d;
      end
   end

   assign smp.sample_ready = ready_q;
   assign temperature      = temperature_q;
   assign temp_valid       = temp_valid_q;
   assign humanDetector    = human_q;

endmodule

// File: tb/tb_sensor_frontend.sv
// Bench for sensor_frontend: a scoreboard queue holds expected temperatures and
// their arrival times; a negedge monitor pops one entry per temp_valid pulse.
module tb_sensor_frontend;

   logic       clk;
   logic       rst_n;
   logic       pir_raw;
   logic [6:0] temperature;
   logic       temp_valid;
   logic       humanDetector;

   int checks;
   int errors;

   typedef struct {
      logic [6:0] val;
      time        t;
   } exp_t;

   exp_t sb_q[$];

   sensor_frontend_if bus ();

   sensor_frontend #(
      .AVG_LOG2    (2),
      .DEBOUNCE    (4),
      .HOLD_CYCLES (16)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .smp           (bus),
      .pir_raw       (pir_raw),
      .temperature   (temperature),
      .temp_valid    (temp_valid),
      .humanDetector (humanDetector)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      exp_t e;
      if (temp_valid === 1'b1) begin
         checks++;
         if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL temp_unexpected: got=%0d at t=%0t, none expected", temperature, $time);
         end else begin
            e = sb_q.pop_front();
            if (temperature !== e.val || $time != e.t) begin
               errors++;
               $display("FAIL temp_out: got=%0d at t=%0t, expected=%0d at t=%0t",
                        temperature, $time, e.val, e.t);
            end
         end
      end
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=%0d expected=%0d at t=%0t", name, got, exp, $time);
      end
   endtask

   task automatic expect_push(input logic [6:0] v);
      exp_t e;
      e.val = v;
      e.t   = $time + 30;
      sb_q.push_back(e);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_temperature"}, 32'(temperature), 32'd0);
      check({tag, "_temp_valid"}, 32'(temp_valid), 32'd0);
      check({tag, "_ready"}, 32'(bus.sample_ready), 32'd0);
      check({tag, "_human"}, 32'(humanDetector), 32'd0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1 check_all_zero("reset");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("ready_after_release", 32'(bus.sample_ready), 32'd1);
   endtask

   task automatic send(input logic [7:0] d, input logic [6:0] exp);
      int n;
      n = 0;
      @(negedge clk);
      bus.sample_valid = 1'b1;
      bus.sample_data  = d;
      while (bus.sample_ready !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (n >= 20) begin
         checks++;
         errors++;
         $display("FAIL send_timeout: ready=%b expected=1", bus.sample_ready);
      end else begin
         expect_push(exp);
      end
      @(negedge clk);
      bus.sample_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb_q.size() != 0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("drain_pending", 32'(sb_q.size()), 32'd0);
   endtask

   initial begin
      logic [7:0] stream_data [12];
      logic [6:0] stream_exp  [4];
      int         n;
      logic       exp_h;

      checks           = 0;
      errors           = 0;
      rst_n            = 1'b0;
      pir_raw          = 1'b0;
      bus.sample_valid = 1'b0;
      bus.sample_data  = 8'd0;

      #1 check_all_zero("init");
      @(negedge clk);
      check("ready_in_reset", 32'(bus.sample_ready), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      check("ready_after_release", 32'(bus.sample_ready), 32'd1);

      // First sample preloads; then the window fills with 29.
      send(8'd25, 7'd25);
      send(8'd29, 7'd26);
      send(8'd29, 7'd27);
      send(8'd29, 7'd28);
      send(8'd29, 7'd29);
      drain();
      repeat (5) @(negedge clk);
      check("temperature_holds", 32'(temperature), 32'd29);

      // Negative clamp, then full-scale accumulation.
      do_reset();
      send(8'hF8, 7'd0);
      send(8'd127, 7'd31);
      send(8'd127, 7'd63);
      send(8'd127, 7'd95);
      send(8'd127, 7'd127);
      drain();

      // Abort while in ACCUM; the next sample must preload, not blend with 127s.
      @(negedge clk);
      bus.sample_valid = 1'b1;
      bus.sample_data  = 8'd10;
      n = 0;
      while (bus.sample_ready !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("accum_abort_ready_seen", 32'(bus.sample_ready), 32'd1);
      @(negedge clk);
      bus.sample_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1 check_all_zero("accum_reset");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("ready_after_accum_reset", 32'(bus.sample_ready), 32'd1);
      send(8'd40, 7'd40);
      drain();

      // Continuous valid: only every third word (ready high) may be used.
      stream_data = '{8'd40, 8'd99, 8'd99, 8'd44, 8'd99, 8'd99,
                      8'd48, 8'd99, 8'd99, 8'd52, 8'd99, 8'd99};
      stream_exp  = '{7'd40, 7'd41, 7'd43, 7'd46};
      do_reset();
      for (int i = 0; i < 12; i++) begin
         bus.sample_valid = 1'b1;
         bus.sample_data  = stream_data[i];
         check($sformatf("stream_ready_%0d", i), 32'(bus.sample_ready), 32'((i % 3) == 0));
         if ((i % 3) == 0) expect_push(stream_exp[i / 3]);
         @(negedge clk);
      end
      bus.sample_valid = 1'b0;
      drain();

      // Three-cycle PIR glitch is filtered out.
      @(negedge clk);
      pir_raw = 1'b1;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (k == 3) pir_raw = 1'b0;
         check($sformatf("pir_short_k%0d", k), 32'(humanDetector), 32'd0);
      end

      // Ten-cycle pulse, then a second pulse during the hold that reloads it.
      @(negedge clk);
      pir_raw = 1'b1;
      for (int k = 1; k <= 60; k++) begin
         @(negedge clk);
         if (k == 10) pir_raw = 1'b0;
         if (k == 19) pir_raw = 1'b1;
         if (k == 29) pir_raw = 1'b0;
         exp_h = (k >= 7) && (k <= 51);
         check($sformatf("pir_hold_k%0d", k), 32'(humanDetector), 32'(exp_h));
      end

      // Reset during the hold clears the flag and the hold count.
      @(negedge clk);
      pir_raw = 1'b1;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (k == 10) pir_raw = 1'b0;
      end
      check("pir_in_hold", 32'(humanDetector), 32'd1);
      #2 rst_n = 1'b0;
      #1 check_all_zero("hold_reset");
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      check("pir_after_hold_reset", 32'(humanDetector), 32'd0);

      drain();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/sensor_frontend.md
Name: sensor_frontend

Overview:
- Upstream conditioning stage for the airConditioning controller.
- Accepts raw signed temperature samples over a valid/ready handshake, clamps them to 0..127 and smooths them with a moving average.
- Synchronises and debounces the raw PIR motion input, then applies an occupancy hold timer.
- Drives `temperature[6:0]` and `humanDetector`, which connect directly to the controller's inputs of the same names.

Parameters:
- `AVG_LOG2`, 2, log2 of moving-average window depth (window = 4 samples).
- `DEBOUNCE`, 4, consecutive synchronised cycles `pir_raw` must be stable before a level change is accepted.
- `HOLD_CYCLES`, 16, cycles `humanDetector` stays high after debounced PIR falls.

Ports:
- `clk`  in  1  single system clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `sample_valid`  in  1  raw temperature sample present.
- `sample_data`  in  8  raw temperature, two's complement, degrees C.
- `sample_ready`  out  1  block can accept a sample this cycle.
- `pir_raw`  in  1  asynchronous PIR motion sensor level.
- `temperature`  out  7  averaged, clamped temperature; feeds downstream.
- `temp_valid`  out  1  one-cycle pulse when `temperature` updates.
- `humanDetector`  out  1  occupancy flag; feeds downstream.

Behaviour:
- Reset: asserting `rst_n` low immediately clears all outputs and state.
  - `temperature`=0, `temp_valid`=0, `sample_ready`=0, `humanDetector`=0.
  - Ring buffer and sum cleared; `first` flag set; synchroniser, debounce count and hold count = 0; FSM = IDLE.
- Temperature FSM (IDLE -> ACCUM -> OUTPUT -> IDLE):
  - IDLE: `sample_ready`=1. A sample is accepted on an edge where `sample_valid`&`sample_ready`; the clamped value is latched and the FSM moves to ACCUM.
  - Clamp: negative -> 0; 0..127 passes unchanged (8-bit signed max is 127).
  - ACCUM: `sample_ready`=0.
    - If `first`: every buffer entry = clamped value, sum = value << `AVG_LOG2`, clear `first`.
    - Else: sum = sum - oldest + new, oldest entry overwritten, write pointer wraps modulo 2^`AVG_LOG2`.
    - Sum width is 7+`AVG_LOG2` bits and never overflows.
  - OUTPUT: `sample_ready`=0, `temperature` = sum >> `AVG_LOG2` (truncating), `temp_valid`=1 for exactly this cycle. Next state IDLE.
  - Latency: sample accepted at edge N -> `temperature`/`temp_valid` visible after edge N+2. Throughput 1 sample per 3 cycles.
  - `sample_valid` while `sample_ready`=0 is ignored; the source must hold data until the handshake.
  - `temperature` holds its value between updates.
- PIR path:
  - 2-flop synchroniser, then debouncer: the debounced level `pir_db` changes only after the synchronised input differs from `pir_db` for `DEBOUNCE` consecutive cycles. Any return to the old level resets the count.
  - Hold counter: loads `HOLD_CYCLES` every cycle `pir_db`=1. When `pir_db`=0 and count>0 it decrements by 1; it saturates at 0.
  - `humanDetector` is registered: next = `pir_db` | (count != 0).
  - After `pir_db` falls, `humanDetector` remains 1 for exactly `HOLD_CYCLES` further cycles.
  - Re-rise of `pir_db` during hold reloads the counter; no low glitch on `humanDetector`.
- Reset mid-operation: any FSM state aborts; after release the first accepted sample is treated as a first sample (buffer preload). `sample_ready` returns to 1 on the first edge after release.
- The temperature and PIR paths are independent and may update in the same cycle.

Test Plan:
- Reset, send 25 -> `temperature`=25 with a single `temp_valid` pulse 2 edges after acceptance. Then send 29 x4 -> outputs 26, 27, 28, 29.
- Send 0xF8 (-8) as the first sample -> `temperature`=0. Then send 127 x4 -> 31, 63, 95, 127, with no overflow.
- Hold `sample_valid`=1 continuously with changing data -> `sample_ready` pattern 1,0,0 repeating; exactly one sample accepted per 3 cycles; ignored data never appears in the average.
- `pir_raw` high for 3 cycles -> `humanDetector` stays 0. `pir_raw` high for 10 cycles -> `humanDetector` rises; after the debounced fall it stays 1 for exactly 16 cycles, then 0.
- During hold (count=8), `pir_raw` re-asserts long enough to debounce -> `humanDetector` never drops; count reloads to 16.
- Drive `rst_n` low during ACCUM and during the PIR hold -> all outputs 0 asynchronously. After release, sample 40 -> `temperature`=40 (preload, not averaged with pre-reset data).
